// File: rtl/reorder_buffer.sv
`default_nettype none
// ==========================================================================
// reorder_buffer : circular ROB with tag allocation, CDB capture, operand
//                  lookup and in-order commit with branch flush
// Revision 1.0
// ==========================================================================
module reorder_buffer #(
  parameter int SIZE  = 16,
  parameter int WIDTH = 32,
  localparam int TW   = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dispatch,
  input  logic [4:0]       dispatch_rd,
  input  logic [6:0]       dispatch_opcode,
  output logic [TW-1:0]    rob_entry,
  output logic             rob_full,
  input  logic             cdb_valid,
  input  logic [TW-1:0]    cdb_tag,
  input  logic [WIDTH-1:0] cdb_value,
  input  logic             cdb_br_en,
  input  logic [WIDTH-1:0] cdb_br_target,
  input  logic             tag1_valid,
  input  logic             tag2_valid,
  input  logic [TW-1:0]    tag_in1,
  input  logic [TW-1:0]    tag_in2,
  output logic             op1_ready,
  output logic             op2_ready,
  output logic [WIDTH-1:0] op1_value,
  output logic [WIDTH-1:0] op2_value,
  output logic             commit_ready,
  output logic [TW-1:0]    commit_tag,
  output logic [4:0]       commit_rds,
  output logic [WIDTH-1:0] commit_val,
  output logic             commit_br_en,
  output logic [WIDTH-1:0] commit_br_target,
  output logic [6:0]       commit_opcode,
  output logic             flush
);

  localparam logic [TW:0]   FULL_COUNT = (TW+1)'(SIZE);
  localparam logic [TW:0]   ONE_COUNT  = (TW+1)'(1);
  localparam logic [TW-1:0] ONE_PTR    = TW'(1);

  logic [SIZE-1:0]  valid;
  logic [SIZE-1:0]  done;
  logic [SIZE-1:0]  br_en;
  logic [4:0]       rd        [SIZE];
  logic [6:0]       opcode    [SIZE];
  logic [WIDTH-1:0] value     [SIZE];
  logic [WIDTH-1:0] br_target [SIZE];

  logic [TW-1:0] head;
  logic [TW-1:0] tail;
  logic [TW:0]   count;

  logic dispatch_ok;
  logic retire;
  logic cdb_hit;

  // Full/entry come only from registered state, so no commit-to-dispatch path.
  assign rob_entry   = tail;
  assign rob_full    = (count == FULL_COUNT);
  assign dispatch_ok = dispatch && !rob_full;
  assign retire      = valid[head] && done[head];
  assign cdb_hit     = cdb_valid && valid[cdb_tag];

  assign commit_ready     = retire;
  assign commit_tag       = head;
  assign commit_rds       = (rd[head] == 5'd0) ? 5'd0 : rd[head];
  assign commit_val       = (rd[head] == 5'd0) ? '0 : value[head];
  assign commit_br_en     = br_en[head];
  assign commit_br_target = br_target[head];
  assign commit_opcode    = opcode[head];
  assign flush            = retire && br_en[head];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      done  <= '0;
    end else begin
      if (cdb_hit) begin
        done[cdb_tag] <= 1'b1;
      end
      if (retire) begin
        valid[head] <= 1'b0;
        head        <= head + ONE_PTR;
      end
      // The tail slot is never valid when dispatch is accepted, so it cannot
      // collide with a CDB write or a retirement.
      if (dispatch_ok) begin
        valid[tail] <= 1'b1;
        done[tail]  <= 1'b0;
        tail        <= tail + ONE_PTR;
      end
      case ({dispatch_ok, retire})
        2'b10:   count <= count + ONE_COUNT;
        2'b01:   count <= count - ONE_COUNT;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush) begin
      if (dispatch_ok) begin
        rd[tail]        <= dispatch_rd;
        opcode[tail]    <= dispatch_opcode;
        value[tail]     <= '0;
        br_en[tail]     <= 1'b0;
        br_target[tail] <= '0;
      end
      if (cdb_hit) begin
        value[cdb_tag]     <= cdb_value;
        br_en[cdb_tag]     <= cdb_br_en;
        br_target[cdb_tag] <= cdb_br_target;
      end
    end
  end

  // The in-flight CDB result wins over the stored value.
  always_comb begin
    op1_ready = 1'b0;
    op1_value = '0;
    if (tag1_valid) begin
      if (cdb_valid && (cdb_tag == tag_in1)) begin
        op1_ready = 1'b1;
        op1_value = cdb_value;
      end else if (valid[tag_in1] && done[tag_in1]) begin
        op1_ready = 1'b1;
        op1_value = value[tag_in1];
      end
    end
  end

  always_comb begin
    op2_ready = 1'b0;
    op2_value = '0;
    if (tag2_valid) begin
      if (cdb_valid && (cdb_tag == tag_in2)) begin
        op2_ready = 1'b1;
        op2_value = cdb_value;
      end else if (valid[tag_in2] && done[tag_in2]) begin
        op2_ready = 1'b1;
        op2_value = value[tag_in2];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ==========================================================================
// tb_reorder_buffer : directed + randomized bench for reorder_buffer,
//                     checked against a program-order queue model
// Revision 1.0
// ==========================================================================
module tb_reorder_buffer;

  localparam int SIZE  = 16;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             dispatch;
  logic [4:0]       dispatch_rd;
  logic [6:0]       dispatch_opcode;
  logic [3:0]       rob_entry;
  logic             rob_full;
  logic             cdb_valid;
  logic [3:0]       cdb_tag;
  logic [WIDTH-1:0] cdb_value;
  logic             cdb_br_en;
  logic [WIDTH-1:0] cdb_br_target;
  logic             tag1_valid, tag2_valid;
  logic [3:0]       tag_in1, tag_in2;
  logic             op1_ready, op2_ready;
  logic [WIDTH-1:0] op1_value, op2_value;
  logic             commit_ready;
  logic [3:0]       commit_tag;
  logic [4:0]       commit_rds;
  logic [WIDTH-1:0] commit_val;
  logic             commit_br_en;
  logic [WIDTH-1:0] commit_br_target;
  logic [6:0]       commit_opcode;
  logic             flush;

  always #5 clk = ~clk;

  reorder_buffer #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .dispatch(dispatch), .dispatch_rd(dispatch_rd), .dispatch_opcode(dispatch_opcode),
    .rob_entry(rob_entry), .rob_full(rob_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_br_en(cdb_br_en), .cdb_br_target(cdb_br_target),
    .tag1_valid(tag1_valid), .tag2_valid(tag2_valid),
    .tag_in1(tag_in1), .tag_in2(tag_in2),
    .op1_ready(op1_ready), .op2_ready(op2_ready),
    .op1_value(op1_value), .op2_value(op2_value),
    .commit_ready(commit_ready), .commit_tag(commit_tag), .commit_rds(commit_rds),
    .commit_val(commit_val), .commit_br_en(commit_br_en),
    .commit_br_target(commit_br_target), .commit_opcode(commit_opcode),
    .flush(flush)
  );

  // Model: in-flight instructions in program order, oldest first.
  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  rd;
    logic [6:0]  op;
    bit          done;
    logic [31:0] val;
    bit          br;
    logic [31:0] tgt;
  } ent_t;

  ent_t q[$];
  int   m_tail = 0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find(input logic [3:0] t);
    foreach (q[i]) if (q[i].tag == t) return i;
    return -1;
  endfunction

  task automatic check_lookup(input string name, input logic tv, input logic [3:0] t,
                              input logic rdy, input logic [31:0] val);
    int          i;
    bit          er;
    logic [31:0] ev;
    i  = find(t);
    er = 1'b0;
    ev = '0;
    if (tv) begin
      if (cdb_valid && cdb_tag == t) begin
        er = 1'b1;
        ev = cdb_value;
      end else if (i >= 0 && q[i].done) begin
        er = 1'b1;
        ev = q[i].val;
      end
    end
    check({name, "_ready"}, 64'(rdy), 64'(er));
    check({name, "_value"}, 64'(val), 64'(ev));
  endtask

  task automatic compare_all();
    bit   ecr;
    ent_t h;
    ecr = (q.size() > 0) && q[0].done;
    check("rob_entry", 64'(rob_entry), 64'(m_tail));
    check("rob_full", 64'(rob_full), 64'(q.size() == SIZE));
    check("commit_ready", 64'(commit_ready), 64'(ecr));
    check("flush", 64'(flush), 64'(ecr && q[0].br));
    if (ecr) begin
      h = q[0];
      check("commit_tag", 64'(commit_tag), 64'(h.tag));
      check("commit_rds", 64'(commit_rds), 64'(h.rd));
      check("commit_val", 64'(commit_val), (h.rd == 5'd0) ? 64'(0) : 64'(h.val));
      check("commit_br_en", 64'(commit_br_en), 64'(h.br));
      check("commit_br_target", 64'(commit_br_target), 64'(h.tgt));
      check("commit_opcode", 64'(commit_opcode), 64'(h.op));
    end
    check_lookup("op1", tag1_valid, tag_in1, op1_ready, op1_value);
    check_lookup("op2", tag2_valid, tag_in2, op2_ready, op2_value);
  endtask

  always @(negedge clk) if (chk_en) compare_all();

  always @(posedge clk) begin
    bit   full, ret, fl;
    int   i;
    ent_t e;
    if (!rst) begin
      q.delete();
      m_tail = 0;
    end else begin
      full = (q.size() == SIZE);
      ret  = (q.size() > 0) && q[0].done;
      fl   = ret && q[0].br;
      if (fl) begin
        q.delete();
        m_tail = 0;
      end else begin
        if (cdb_valid) begin
          i = find(cdb_tag);
          if (i >= 0) begin
            q[i].done = 1'b1;
            q[i].val  = cdb_value;
            q[i].br   = cdb_br_en;
            q[i].tgt  = cdb_br_target;
          end
        end
        if (ret) void'(q.pop_front());
        if (dispatch && !full) begin
          e.tag  = 4'(m_tail);
          e.rd   = dispatch_rd;
          e.op   = dispatch_opcode;
          e.done = 1'b0;
          e.val  = '0;
          e.br   = 1'b0;
          e.tgt  = '0;
          q.push_back(e);
          m_tail = (m_tail + 1) % SIZE;
        end
      end
    end
  end

  task automatic idle();
    rst = 1'b1;
    dispatch = 1'b0; dispatch_rd = '0; dispatch_opcode = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; cdb_br_en = 1'b0; cdb_br_target = '0;
    tag1_valid = 1'b0; tag2_valid = 1'b0; tag_in1 = '0; tag_in2 = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic disp(input logic [4:0] r, input logic [6:0] o);
    dispatch = 1'b1; dispatch_rd = r; dispatch_opcode = o;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] v, input logic b, input logic [31:0] tg);
    cdb_valid = 1'b1; cdb_tag = t; cdb_value = v; cdb_br_en = b; cdb_br_target = tg;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    chk_en = 1'b1;
    at_neg();
    check("reset_rob_entry", 64'(rob_entry), 64'(0));
    check("reset_rob_full", 64'(rob_full), 64'(0));
    check("reset_commit_ready", 64'(commit_ready), 64'(0));
    check("reset_flush", 64'(flush), 64'(0));
    cyc();

    // In-order completion, three back-to-back commits
    idle(); disp(5'd1, 7'h13); cyc();
    idle(); disp(5'd2, 7'h13); cyc();
    idle(); disp(5'd3, 7'h13); cyc();
    idle(); cdb(4'd0, 32'd10, 1'b0, 32'd0); at_neg();
    check("s1_no_early_commit", 64'(commit_ready), 64'(0)); cyc();
    idle(); cdb(4'd1, 32'd20, 1'b0, 32'd0); at_neg();
    check("s1_c0_ready", 64'(commit_ready), 64'(1));
    check("s1_c0_tag", 64'(commit_tag), 64'(0));
    check("s1_c0_val", 64'(commit_val), 64'(10)); cyc();
    idle(); cdb(4'd2, 32'd30, 1'b0, 32'd0); at_neg();
    check("s1_c1_tag", 64'(commit_tag), 64'(1));
    check("s1_c1_val", 64'(commit_val), 64'(20)); cyc();
    idle(); at_neg();
    check("s1_c2_tag", 64'(commit_tag), 64'(2));
    check("s1_c2_val", 64'(commit_val), 64'(30));
    check("s1_c2_rds", 64'(commit_rds), 64'(3)); cyc();
    at_neg();
    check("s1_drained", 64'(commit_ready), 64'(0));
    check("s1_rob_entry", 64'(rob_entry), 64'(3)); cyc();

    // Out-of-order completion
    do_reset();
    idle(); disp(5'd5, 7'h33); cyc();
    idle(); disp(5'd6, 7'h33); cyc();
    idle(); cdb(4'd1, 32'd7, 1'b0, 32'd0); at_neg();
    check("s2_wait_a", 64'(commit_ready), 64'(0)); cyc();
    idle(); cdb(4'd0, 32'd5, 1'b0, 32'd0); at_neg();
    check("s2_wait_b", 64'(commit_ready), 64'(0)); cyc();
    idle(); at_neg();
    check("s2_c0_tag", 64'(commit_tag), 64'(0));
    check("s2_c0_val", 64'(commit_val), 64'(5)); cyc();
    at_neg();
    check("s2_c1_tag", 64'(commit_tag), 64'(1));
    check("s2_c1_val", 64'(commit_val), 64'(7)); cyc();

    // Fill, overflow attempt, commit-while-full, wrap
    do_reset();
    for (int i = 0; i < SIZE; i++) begin
      idle(); disp(5'(i + 1), 7'h03); cyc();
    end
    idle(); disp(5'd17, 7'h03); at_neg();
    check("s3_full", 64'(rob_full), 64'(1)); cyc();
    idle(); at_neg();
    check("s3_tail_held", 64'(rob_entry), 64'(0));
    check("s3_still_full", 64'(rob_full), 64'(1)); cyc();
    idle(); cdb(4'd0, 32'd111, 1'b0, 32'd0); disp(5'd20, 7'h03); cyc();
    idle(); disp(5'd21, 7'h03); at_neg();
    check("s3_commit_while_full", 64'(commit_ready), 64'(1)); cyc();
    idle(); at_neg();
    check("s3_room", 64'(rob_full), 64'(0));
    check("s3_wrap_tag", 64'(rob_entry), 64'(0));
    disp(5'd9, 7'h03); cyc();
    idle(); at_neg();
    check("s3_refull", 64'(rob_full), 64'(1));
    check("s3_tail_after", 64'(rob_entry), 64'(1)); cyc();

    // Mispredicted branch at tag 2 flushes younger done entries
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle(); disp(5'(i + 1), 7'h63); cyc();
    end
    idle(); cdb(4'd3, 32'd33, 1'b0, 32'd0); cyc();
    idle(); cdb(4'd4, 32'd44, 1'b0, 32'd0); cyc();
    idle(); cdb(4'd2, 32'h22, 1'b1, 32'h40); cyc();
    idle(); cdb(4'd0, 32'd1, 1'b0, 32'd0); cyc();
    idle(); cdb(4'd1, 32'd2, 1'b0, 32'd0); at_neg();
    check("s4_c0_tag", 64'(commit_tag), 64'(0)); cyc();
    idle(); at_neg();
    check("s4_c1_tag", 64'(commit_tag), 64'(1)); cyc();
    idle(); disp(5'd7, 7'h13); cdb(4'd3, 32'd99, 1'b0, 32'd0); at_neg();
    check("s4_flush", 64'(flush), 64'(1));
    check("s4_br_tag", 64'(commit_tag), 64'(2));
    check("s4_br_target", 64'(commit_br_target), 64'(32'h40)); cyc();
    idle(); at_neg();
    check("s4_after_ready", 64'(commit_ready), 64'(0));
    check("s4_after_entry", 64'(rob_entry), 64'(0));
    check("s4_after_flush", 64'(flush), 64'(0)); cyc();

    // Operand lookup with CDB bypass and not-done tag
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle(); disp(5'(i + 1), 7'h13); cyc();
    end
    idle(); cdb(4'd5, 32'hABCD, 1'b0, 32'd0);
    tag1_valid = 1'b1; tag_in1 = 4'd5; tag2_valid = 1'b1; tag_in2 = 4'd4; at_neg();
    check("s5_bypass_ready", 64'(op1_ready), 64'(1));
    check("s5_bypass_value", 64'(op1_value), 64'(32'hABCD));
    check("s5_notdone_ready", 64'(op2_ready), 64'(0));
    check("s5_notdone_value", 64'(op2_value), 64'(0)); cyc();
    idle(); tag1_valid = 1'b1; tag_in1 = 4'd5; at_neg();
    check("s5_stored_value", 64'(op1_value), 64'(32'hABCD)); cyc();

    // rd==0 masking, then mid-sequence reset
    do_reset();
    idle(); disp(5'd0, 7'h13); cyc();
    idle(); cdb(4'd0, 32'd99, 1'b0, 32'd0); cyc();
    idle(); at_neg();
    check("s6_x0_ready", 64'(commit_ready), 64'(1));
    check("s6_x0_rds", 64'(commit_rds), 64'(0));
    check("s6_x0_val", 64'(commit_val), 64'(0));
    disp(5'd4, 7'h13); cyc();
    idle(); cdb(4'd1, 32'd5, 1'b0, 32'd0); cyc();
    idle(); rst = 1'b0; cyc();
    rst = 1'b1; at_neg();
    check("s6_reset_ready", 64'(commit_ready), 64'(0));
    check("s6_reset_entry", 64'(rob_entry), 64'(0)); cyc();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int dprob;
      dprob = ((n / 400) % 2 == 0) ? 80 : 35;
      idle();
      rst       = ($urandom_range(0, 299) != 0);
      dispatch  = ($urandom_range(0, 99) < dprob);
      dispatch_rd     = 5'($urandom_range(0, 31));
      dispatch_opcode = 7'($urandom_range(0, 127));
      cdb_valid = ($urandom_range(0, 9) < 7);
      if (q.size() > 0 && $urandom_range(0, 4) != 0)
        cdb_tag = q[$urandom_range(0, q.size() - 1)].tag;
      else
        cdb_tag = 4'($urandom_range(0, 15));
      cdb_value     = $urandom();
      cdb_br_en     = ($urandom_range(0, 19) == 0);
      cdb_br_target = $urandom();
      tag1_valid = 1'($urandom_range(0, 1));
      tag2_valid = 1'($urandom_range(0, 1));
      tag_in1 = ($urandom_range(0, 9) < 3) ? cdb_tag : 4'($urandom_range(0, 15));
      tag_in2 = 4'($urandom_range(0, 15));
      cyc();
    end

    idle();
    cyc();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
